fp_vector_scatter: RTL and testbench
====================================

FP_VECTOR_SCATTER -- requirements
Module: fp_vector_scatter

Interface
REQ-001 SHALL have parameter NUM_FP_POINTS, default 8; the number of output lanes; legal values 2, 4, 8, 16.
REQ-002 SHALL have port clk, input, 1 bit; the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; asynchronous active-high reset.
REQ-004 SHALL have port fp_in, input, 32 bits; the scalar single-precision word.
REQ-005 SHALL have port fp_in_valid, input, 1 bit; fp_in holds a word.
REQ-006 SHALL have port fp_in_last, input, 1 bit; the word is the final word of its group.
REQ-007 SHALL have port fp_in_ready, output, 1 bit; the block accepts fp_in this cycle.
REQ-008 SHALL have port fp_out_vector[NUM_FP_POINTS-1:0], output, 32 bits per lane; one word per lane.
REQ-009 SHALL have port fp_out_vector_valid[NUM_FP_POINTS-1:0], output, 1 bit per lane; lane data is valid.
REQ-010 SHALL have port fp_out_vector_last[NUM_FP_POINTS-1:0], output, 1 bit per lane; the vector closes its group.
REQ-011 SHALL have port fp_out_vector_ready[NUM_FP_POINTS-1:0], input, 1 bit per lane; the lane consumer accepts.

Function
REQ-012 SHALL accept a word only on the cycle where fp_in_valid and fp_in_ready are both high.
REQ-013 SHALL write the k-th accepted word of a vector (k = 0..N-1) into staging lane k, under a lane counter that wraps at N.
REQ-014 SHALL set stage_full on the clock edge that accepts either lane N-1 or any word with fp_in_last high.
REQ-015 SHALL, on a word accepted with last at lane k < N-1, fill staging lanes k+1..N-1 with 32'h0 and reset the lane counter to 0.
- 32'h0 is neutral for the downstream reduction.
REQ-016 SHALL drive fp_in_ready = ~stage_full, a registered value with no combinational path from fp_out_vector_ready.
REQ-017 SHALL define out_free for a cycle as: every lane's pending bit is clear, or every set pending bit has its ready high in that cycle.
REQ-018 SHALL, on an edge where stage_full and out_free are both high:
- copy the staging vector into the output registers;
- set all N pending bits;
- set last on all lanes equal to the group-closing flag;
- clear stage_full.
REQ-019 SHALL drive fp_out_vector_valid[i] = pending[i], and SHALL clear pending[i] only on an edge where pending[i] and fp_out_vector_ready[i] are both high.
- Lanes drain independently.
REQ-020 SHALL hold fp_out_vector[i] and fp_out_vector_last[i] stable while pending[i] is set.
REQ-021 SHALL meet this latency: completing word accepted at edge E0, output free → all lanes valid after E1; fp_in_ready is low for exactly the cycle between E0 and E1.
REQ-022 SHALL sustain a best-case throughput of N words per N+1 cycles.
REQ-023 SHALL hold staging when out_free is false, with fp_in_ready low and no data loss, until the transfer of REQ-018 occurs.
REQ-024 SHALL ignore fp_in_last when fp_in_valid is low.

Reset
REQ-025 SHALL, while rst is high, asynchronously clear:
- lane counter to 0;
- stage_full to 0;
- all pending bits to 0;
- all fp_out_vector to 32'h0;
- all fp_out_vector_last to 0.
REQ-026 SHALL drive fp_in_ready to 0 while rst is high, and to 1 on the first cycle after rst deasserts.
REQ-027 SHALL discard any partial or undrained vector on reset mid-operation, with no output on the cycle after deassertion.

Configuration
REQ-028 SHALL, with macro FP_SCATTER_STATS_EN defined, add the following output counters, each 32 bits, reset to 0 and wrapping at 2^32:
- vec_count: incremented on each REQ-018 transfer;
- pad_count: incremented by the number of zero-filled lanes in each transfer.
REQ-029 SHALL, without FP_SCATTER_STATS_EN, have neither port nor the related logic, with identical datapath behaviour.

Structure
REQ-030 SHALL take FP_WIDTH (32), FP_ZERO (32'h0) and the lane-index width function from shared package fp_tree_pkg, which the reduce tree also uses.
REQ-031 SHALL instantiate one sub-module per lane, fp_scatter_lane_reg, holding data, last and pending with its own valid/ready.

Verification
REQ-032 SHALL cover: N=8, words 1.0..8.0 sent back-to-back with all readies high → a single vector 1.0..8.0 with last=0; fp_in_ready low for 1 cycle after the 8th word.
REQ-033 SHALL cover: N=8, 3 words 2.0, 3.0, 4.0 with last on the third → lanes 0-2 carry the data, lanes 3-7 carry 32'h0, all last=1; pad_count=5 when FP_SCATTER_STATS_EN is defined.
REQ-034 SHALL cover: a single word with last → lane 0 carries the word, lanes 1..N-1 are zero, all valid and last.
REQ-035 SHALL cover: lane 5 ready held low for 10 cycles, other lanes ready → lane 5 alone stays valid; the next full staging vector is not transferred until lane 5 drains; fp_in_ready stays low meanwhile.
REQ-036 SHALL cover: rst pulsed after 4 of 8 words → all valid bits 0 immediately; after release, 8 new words give a vector with only the new data.

Source files
------------

// File: rtl/fp_tree_pkg.sv
// fp_tree_pkg: word format and lane-index sizing shared by the scatter front end and the reduce tree.
package fp_tree_pkg;
    localparam int FP_WIDTH = 32;
    localparam logic [FP_WIDTH-1:0] FP_ZERO = 32'h0;

    function automatic int lane_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fp_scatter_lane_reg.sv
// fp_scatter_lane_reg: one output lane holding data, last and a pending flag behind its own valid/ready.
module fp_scatter_lane_reg
    import fp_tree_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [FP_WIDTH-1:0] d,
    input  logic                last_in,
    input  logic                ready,
    output logic [FP_WIDTH-1:0] data,
    output logic                last,
    output logic                valid
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= FP_ZERO;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= d;
            last  <= last_in;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fp_vector_scatter.sv
// fp_vector_scatter: packs a scalar FP word stream into N-lane vectors, zero-padding short groups.
// Optional FP_SCATTER_STATS_EN adds vec_count/pad_count transfer statistics.
module fp_vector_scatter
    import fp_tree_pkg::*;
#(
    parameter int NUM_FP_POINTS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef FP_SCATTER_STATS_EN
    output logic [31:0]              vec_count,
    output logic [31:0]              pad_count,
`endif
    input  logic [FP_WIDTH-1:0]      fp_in,
    input  logic                     fp_in_valid,
    input  logic                     fp_in_last,
    output logic                     fp_in_ready,
    output logic [FP_WIDTH-1:0]      fp_out_vector [NUM_FP_POINTS],
    output logic [NUM_FP_POINTS-1:0] fp_out_vector_valid,
    output logic [NUM_FP_POINTS-1:0] fp_out_vector_last,
    input  logic [NUM_FP_POINTS-1:0] fp_out_vector_ready
);
    localparam int IW = lane_idx_w(NUM_FP_POINTS);
    localparam logic [IW-1:0] LAST_LANE = IW'(NUM_FP_POINTS - 1);

    logic [IW-1:0]       cnt;
    logic                stage_full;
    logic                stage_last;
    logic [FP_WIDTH-1:0] stage [NUM_FP_POINTS];
    logic                acc;
    logic                closing;
    logic                out_free;
    logic                xfer;

    assign acc         = fp_in_valid & ~stage_full;
    assign closing     = acc & (fp_in_last | (cnt == LAST_LANE));
    assign out_free    = &(~fp_out_vector_valid | fp_out_vector_ready);
    assign xfer        = stage_full & out_free;
    assign fp_in_ready = ~stage_full & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            stage_full <= 1'b0;
            stage_last <= 1'b0;
            for (int i = 0; i < NUM_FP_POINTS; i++) stage[i] <= FP_ZERO;
        end else begin
            if (acc) begin
                // lanes past the closing word are padded so the reduction sees neutral zeros
                for (int i = 0; i < NUM_FP_POINTS; i++) begin
                    if (IW'(i) == cnt) stage[i] <= fp_in;
                    else if (closing && IW'(i) > cnt) stage[i] <= FP_ZERO;
                end
                cnt <= closing ? '0 : cnt + IW'(1);
            end
            if (closing) begin
                stage_full <= 1'b1;
                stage_last <= fp_in_last;
            end else if (xfer) begin
                stage_full <= 1'b0;
            end
        end
    end

`ifdef FP_SCATTER_STATS_EN
    logic [IW-1:0] pad_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_q     <= '0;
            vec_count <= '0;
            pad_count <= '0;
        end else begin
            if (closing) pad_q <= LAST_LANE - cnt;
            if (xfer) begin
                vec_count <= vec_count + 32'd1;
                pad_count <= pad_count + 32'(pad_q);
            end
        end
    end
`endif

    for (genvar g = 0; g < NUM_FP_POINTS; g++) begin : g_lane
        fp_scatter_lane_reg u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (xfer),
            .d       (stage[g]),
            .last_in (stage_last),
            .ready   (fp_out_vector_ready[g]),
            .data    (fp_out_vector[g]),
            .last    (fp_out_vector_last[g]),
            .valid   (fp_out_vector_valid[g])
        );
    end
endmodule

// File: tb/tb_fp_vector_scatter.sv
// tb_fp_vector_scatter: directed checks of vector packing, padding, lane stalls and reset for N=8.
module tb_fp_vector_scatter;
    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   fp_in = '0;
    logic          fp_in_valid = 1'b0;
    logic          fp_in_last = 1'b0;
    logic          fp_in_ready;
    logic [31:0]   fp_out_vector [N];
    logic [N-1:0]  fp_out_vector_valid;
    logic [N-1:0]  fp_out_vector_last;
    logic [N-1:0]  fp_out_vector_ready = '1;
`ifdef FP_SCATTER_STATS_EN
    logic [31:0]   vec_count;
    logic [31:0]   pad_count;
`endif

    int total = 0;
    int passed = 0;
    logic [31:0] f [N] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] exp_vec [N];

    always #5 clk = ~clk;

    fp_vector_scatter #(.NUM_FP_POINTS(N)) dut (
        .clk                 (clk),
        .rst                 (rst),
`ifdef FP_SCATTER_STATS_EN
        .vec_count           (vec_count),
        .pad_count           (pad_count),
`endif
        .fp_in               (fp_in),
        .fp_in_valid         (fp_in_valid),
        .fp_in_last          (fp_in_last),
        .fp_in_ready         (fp_in_ready),
        .fp_out_vector       (fp_out_vector),
        .fp_out_vector_valid (fp_out_vector_valid),
        .fp_out_vector_last  (fp_out_vector_last),
        .fp_out_vector_ready (fp_out_vector_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        fp_in = d;
        fp_in_valid = 1'b1;
        fp_in_last = l;
        tick();
        fp_in_valid = 1'b0;
        fp_in_last = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (fp_in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", fp_in_ready); else passed++;
        total++; if (fp_out_vector_valid !== '0) $display("FAIL rst_valid got=%h exp=00", fp_out_vector_valid); else passed++;
        total++; if (fp_out_vector_last !== '0) $display("FAIL rst_last got=%h exp=00", fp_out_vector_last); else passed++;
        for (int i = 0; i < N; i++) begin
            total++; if (fp_out_vector[i] !== 32'h0) $display("FAIL rst_data[%0d] got=%h exp=0", i, fp_out_vector[i]); else passed++;
        end
        tick();
        rst = 1'b0;
        #1;
        total++; if (fp_in_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", fp_in_ready); else passed++;
`ifdef FP_SCATTER_STATS_EN
        total++; if (vec_count !== 32'd0 || pad_count !== 32'd0) $display("FAIL rst_stats got=%0d/%0d exp=0/0", vec_count, pad_count); else passed++;
`endif
    endtask

    task automatic test_back_to_back();
        logic rdy_ok;
        rdy_ok = 1'b1;
        fp_out_vector_ready = '1;
        fp_in_last = 1'b1;
        tick();
        fp_in_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (fp_in_ready !== 1'b1) rdy_ok = 1'b0;
            send(f[k], 1'b0);
        end
        total++; if (rdy_ok !== 1'b1) $display("FAIL b2b_ready_during got=%b exp=1", rdy_ok); else passed++;
        total++; if (fp_in_ready !== 1'b0) $display("FAIL b2b_ready_gap got=%b exp=0", fp_in_ready); else passed++;
        total++; if (fp_out_vector_valid !== '0) $display("FAIL b2b_early_valid got=%h exp=00", fp_out_vector_valid); else passed++;
        tick();
        total++; if (fp_out_vector_valid !== 8'hFF) $display("FAIL b2b_valid got=%h exp=ff", fp_out_vector_valid); else passed++;
        total++; if (fp_out_vector_last !== 8'h00) $display("FAIL b2b_last got=%h exp=00", fp_out_vector_last); else passed++;
        total++; if (fp_in_ready !== 1'b1) $display("FAIL b2b_ready_back got=%b exp=1", fp_in_ready); else passed++;
        for (int i = 0; i < N; i++) begin
            total++; if (fp_out_vector[i] !== f[i]) $display("FAIL b2b_data[%0d] got=%h exp=%h", i, fp_out_vector[i], f[i]); else passed++;
        end
        tick();
        total++; if (fp_out_vector_valid !== '0) $display("FAIL b2b_drain got=%h exp=00", fp_out_vector_valid); else passed++;
`ifdef FP_SCATTER_STATS_EN
        total++; if (vec_count !== 32'd1 || pad_count !== 32'd0) $display("FAIL b2b_stats got=%0d/%0d exp=1/0", vec_count, pad_count); else passed++;
`endif
    endtask

    task automatic test_partial();
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b0);
        send(32'h40800000, 1'b1);
        total++; if (fp_in_ready !== 1'b0) $display("FAIL part_ready got=%b exp=0", fp_in_ready); else passed++;
        tick();
        exp_vec = '{32'h40000000, 32'h40400000, 32'h40800000, 0, 0, 0, 0, 0};
        total++; if (fp_out_vector_valid !== 8'hFF) $display("FAIL part_valid got=%h exp=ff", fp_out_vector_valid); else passed++;
        total++; if (fp_out_vector_last !== 8'hFF) $display("FAIL part_last got=%h exp=ff", fp_out_vector_last); else passed++;
        for (int i = 0; i < N; i++) begin
            total++; if (fp_out_vector[i] !== exp_vec[i]) $display("FAIL part_data[%0d] got=%h exp=%h", i, fp_out_vector[i], exp_vec[i]); else passed++;
        end
        tick();
`ifdef FP_SCATTER_STATS_EN
        total++; if (vec_count !== 32'd2 || pad_count !== 32'd5) $display("FAIL part_stats got=%0d/%0d exp=2/5", vec_count, pad_count); else passed++;
`endif
    endtask

    task automatic test_single();
        send(32'h40A00000, 1'b1);
        tick();
        total++; if (fp_out_vector_valid !== 8'hFF) $display("FAIL single_valid got=%h exp=ff", fp_out_vector_valid); else passed++;
        total++; if (fp_out_vector_last !== 8'hFF) $display("FAIL single_last got=%h exp=ff", fp_out_vector_last); else passed++;
        total++; if (fp_out_vector[0] !== 32'h40A00000) $display("FAIL single_lane0 got=%h exp=40a00000", fp_out_vector[0]); else passed++;
        for (int i = 1; i < N; i++) begin
            total++; if (fp_out_vector[i] !== 32'h0) $display("FAIL single_pad[%0d] got=%h exp=0", i, fp_out_vector[i]); else passed++;
        end
        tick();
`ifdef FP_SCATTER_STATS_EN
        total++; if (vec_count !== 32'd3 || pad_count !== 32'd12) $display("FAIL single_stats got=%0d/%0d exp=3/12", vec_count, pad_count); else passed++;
`endif
    endtask

    task automatic test_lane_stall();
        logic hold_ok;
        hold_ok = 1'b1;
        fp_out_vector_ready = '1;
        for (int k = 0; k < N; k++) send(f[k], 1'b0);
        tick();
        fp_out_vector_ready = 8'hDF;
        for (int k = 0; k < N; k++) send(32'h11110000 | 32'(k), 1'b0);
        total++; if (fp_in_ready !== 1'b0) $display("FAIL stall_ready got=%b exp=0", fp_in_ready); else passed++;
        total++; if (fp_out_vector_valid !== 8'h20) $display("FAIL stall_valid got=%h exp=20", fp_out_vector_valid); else passed++;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (fp_out_vector_valid !== 8'h20 || fp_in_ready !== 1'b0 || fp_out_vector[5] !== f[5]) hold_ok = 1'b0;
        end
        total++; if (hold_ok !== 1'b1) $display("FAIL stall_hold got=%b exp=1", hold_ok); else passed++;
        fp_out_vector_ready = '1;
        tick();
        total++; if (fp_out_vector_valid !== 8'hFF) $display("FAIL stall_xfer_valid got=%h exp=ff", fp_out_vector_valid); else passed++;
        total++; if (fp_in_ready !== 1'b1) $display("FAIL stall_ready_back got=%b exp=1", fp_in_ready); else passed++;
        for (int i = 0; i < N; i++) begin
            total++; if (fp_out_vector[i] !== (32'h11110000 | 32'(i))) $display("FAIL stall_data[%0d] got=%h exp=%h", i, fp_out_vector[i], 32'h11110000 | 32'(i)); else passed++;
        end
        tick();
`ifdef FP_SCATTER_STATS_EN
        total++; if (vec_count !== 32'd5 || pad_count !== 32'd12) $display("FAIL stall_stats got=%0d/%0d exp=5/12", vec_count, pad_count); else passed++;
`endif
    endtask

    task automatic test_reset_mid();
        fp_out_vector_ready = '0;
        for (int k = 0; k < N; k++) send(f[k], 1'b0);
        tick();
        for (int k = 0; k < 4; k++) send(32'h55550000 | 32'(k), 1'b0);
        rst = 1'b1;
        #1;
        total++; if (fp_out_vector_valid !== '0) $display("FAIL mid_rst_valid got=%h exp=00", fp_out_vector_valid); else passed++;
        total++; if (fp_in_ready !== 1'b0) $display("FAIL mid_rst_ready got=%b exp=0", fp_in_ready); else passed++;
        tick();
        rst = 1'b0;
        #1;
        total++; if (fp_in_ready !== 1'b1 || fp_out_vector_valid !== '0) $display("FAIL mid_release got=%b/%h exp=1/00", fp_in_ready, fp_out_vector_valid); else passed++;
        fp_out_vector_ready = '1;
        for (int k = 0; k < N; k++) send(32'hC0000000 | 32'(k), 1'b0);
        tick();
        total++; if (fp_out_vector_valid !== 8'hFF) $display("FAIL mid_valid got=%h exp=ff", fp_out_vector_valid); else passed++;
        total++; if (fp_out_vector_last !== 8'h00) $display("FAIL mid_last got=%h exp=00", fp_out_vector_last); else passed++;
        for (int i = 0; i < N; i++) begin
            total++; if (fp_out_vector[i] !== (32'hC0000000 | 32'(i))) $display("FAIL mid_data[%0d] got=%h exp=%h", i, fp_out_vector[i], 32'hC0000000 | 32'(i)); else passed++;
        end
        tick();
`ifdef FP_SCATTER_STATS_EN
        total++; if (vec_count !== 32'd1 || pad_count !== 32'd0) $display("FAIL mid_stats got=%0d/%0d exp=1/0", vec_count, pad_count); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_partial();
        test_single();
        test_lane_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
